// File: rtl/computer.sv
`timescale 1ns/1ps
// SAP-style 8-bit microcoded CPU: 16-byte RAM, PC, A/B/IR/MAR/OUT registers,
// add/sub ALU, Z/C/N flags and a fixed seven-step controller with HLT.

package arch_defs_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
endpackage

// Loadable register with synchronous clear.
module cpu_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] latched_data
);
  always_ff @(posedge clk) begin
    if (reset)       latched_data <= '0;
    else if (load_i) latched_data <= data_i;
  end
endmodule

// Program counter: a jump load wins over increment; wraps naturally at 2^W.
module program_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] counter_out
);
  always_ff @(posedge clk) begin
    if (reset)       counter_out <= '0;
    else if (load_i) counter_out <= data_i;
    else if (inc_i)  counter_out <= counter_out + 1'b1;
  end
endmodule

// Word-wide RAM with combinational read and clocked write; contents survive reset.
module ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [2**AW];

  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  task automatic dump();
    for (int i = 0; i < 2**AW; i++) $display("ram[%0d] = %02h", i, mem[i]);
  endtask
endmodule

module computer
  import arch_defs_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] out_val,
  output logic                  flag_zero_o,
  output logic                  flag_carry_o,
  output logic                  flag_negative_o
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_T0 = 3'd1, S_T1 = 3'd2, S_T2 = 3'd3,
    S_T3   = 3'd4, S_T4 = 3'd5, S_T5 = 3'd6, S_T6 = 3'd7
  } step_e;

  typedef enum logic [1:0] {A_SRC_MEM, A_SRC_IMM, A_SRC_ALU} a_src_e;

  step_e step_q, step_d;
  logic  halt_q, halt_d;
  logic  halt;

  logic [ADDR_WIDTH-1:0] pc, mar, mar_d;
  logic [DATA_WIDTH-1:0] ir, a, b, ram_rdata, a_d;
  logic [3:0]            opcode, operand;

  logic   mar_load, mar_sel_pc, ir_load, pc_inc, pc_load;
  logic   a_load, b_load, out_load, ram_we, flags_zn_load, flags_c_load;
  a_src_e a_src;

  logic [DATA_WIDTH:0]   sum_w, diff_w;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;
  logic                  z_q, c_q, n_q, z_d, c_d, n_d;

  assign halt    = halt_q;
  assign opcode  = ir[7:4];
  assign operand = ir[3:0];

  // ---------------- controller: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= S_IDLE;
      halt_q <= 1'b0;
    end else begin
      step_q <= step_d;
      halt_q <= halt_d;
    end
  end

  // ---------------- controller: next state ----------------
  always_comb begin
    step_d = step_q;
    halt_d = halt_q;
    if (!halt_q) begin
      case (step_q)
        S_IDLE:  step_d = S_T0;
        S_T0:    step_d = S_T1;
        S_T1:    step_d = S_T2;
        S_T2:    step_d = S_T3;
        S_T3:    step_d = S_T4;
        S_T4:    step_d = S_T5;
        S_T5:    step_d = S_T6;
        S_T6:    step_d = S_T0;
        default: step_d = S_IDLE;
      endcase
      if (step_q == S_T3 && opcode == OP_HLT) halt_d = 1'b1;
    end
  end

  // ---------------- controller: control word ----------------
  always_comb begin
    mar_load      = 1'b0;
    mar_sel_pc    = 1'b0;
    ir_load       = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    a_load        = 1'b0;
    a_src         = A_SRC_MEM;
    b_load        = 1'b0;
    out_load      = 1'b0;
    ram_we        = 1'b0;
    flags_zn_load = 1'b0;
    flags_c_load  = 1'b0;
    if (!halt_q) begin
      case (step_q)
        S_T0: begin
          mar_load   = 1'b1;
          mar_sel_pc = 1'b1;
        end
        S_T1: begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
        S_T3: begin
          if (opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA}) mar_load = 1'b1;
        end
        S_T4: begin
          case (opcode)
            OP_LDA: begin
              a_load        = 1'b1;
              a_src         = A_SRC_MEM;
              flags_zn_load = 1'b1;
            end
            OP_ADD, OP_SUB: b_load = 1'b1;
            OP_STA:         ram_we = 1'b1;
            OP_LDI: begin
              a_load        = 1'b1;
              a_src         = A_SRC_IMM;
              flags_zn_load = 1'b1;
            end
            default: ;
          endcase
        end
        S_T5: begin
          case (opcode)
            OP_ADD, OP_SUB: begin
              a_load        = 1'b1;
              a_src         = A_SRC_ALU;
              flags_zn_load = 1'b1;
              flags_c_load  = 1'b1;
            end
            OP_JMP:  pc_load  = 1'b1;
            OP_JC:   pc_load  = c_q;
            OP_JZ:   pc_load  = z_q;
            OP_JN:   pc_load  = n_q;
            OP_OUT:  out_load = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // ---------------- datapath ----------------
  // SUB carry is "no borrow", i.e. A >= B, which is the inverted borrow bit.
  assign sum_w     = {1'b0, a} + {1'b0, b};
  assign diff_w    = {1'b0, a} - {1'b0, b};
  assign alu_res   = (opcode == OP_SUB) ? diff_w[DATA_WIDTH-1:0] : sum_w[DATA_WIDTH-1:0];
  assign alu_carry = (opcode == OP_SUB) ? ~diff_w[DATA_WIDTH] : sum_w[DATA_WIDTH];

  assign mar_d = mar_sel_pc ? pc : operand;

  always_comb begin
    case (a_src)
      A_SRC_IMM: a_d = {4'b0000, operand};
      A_SRC_ALU: a_d = alu_res;
      default:   a_d = ram_rdata;
    endcase
  end

  always_comb begin
    z_d = z_q;
    c_d = c_q;
    n_d = n_q;
    if (flags_zn_load) begin
      z_d = (a_d == '0);
      n_d = a_d[DATA_WIDTH-1];
    end
    if (flags_c_load) c_d = alu_carry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z_q <= 1'b0;
      c_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      z_q <= z_d;
      c_q <= c_d;
      n_q <= n_d;
    end
  end

  program_counter #(.W(ADDR_WIDTH)) u_program_counter (
    .clk         (clk),
    .reset       (reset),
    .inc_i       (pc_inc),
    .load_i      (pc_load),
    .data_i      (operand),
    .counter_out (pc)
  );

  cpu_register #(.W(ADDR_WIDTH)) u_register_MAR (
    .clk (clk), .reset (reset), .load_i (mar_load), .data_i (mar_d), .latched_data (mar)
  );

  cpu_register #(.W(DATA_WIDTH)) u_register_IR (
    .clk (clk), .reset (reset), .load_i (ir_load), .data_i (ram_rdata), .latched_data (ir)
  );

  cpu_register #(.W(DATA_WIDTH)) u_register_A (
    .clk (clk), .reset (reset), .load_i (a_load), .data_i (a_d), .latched_data (a)
  );

  cpu_register #(.W(DATA_WIDTH)) u_register_B (
    .clk (clk), .reset (reset), .load_i (b_load), .data_i (ram_rdata), .latched_data (b)
  );

  cpu_register #(.W(DATA_WIDTH)) u_register_OUT (
    .clk (clk), .reset (reset), .load_i (out_load), .data_i (a), .latched_data (out_val)
  );

  ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (mar),
    .wdata_i (a),
    .rdata_o (ram_rdata)
  );

  assign flag_zero_o     = z_q;
  assign flag_carry_o    = c_q;
  assign flag_negative_o = n_q;
endmodule

// File: tb/tb_computer.sv
`timescale 1ns/1ps
// Bench for the SAP-style CPU: an instruction-level model of the ISA predicts
// architectural state at every instruction boundary for directed and random programs.
module tb_computer;
  logic       clk;
  logic       reset;
  logic [7:0] out_val;
  logic       flag_zero_o, flag_carry_o, flag_negative_o;

  int checks = 0;
  int errors = 0;

  // Instruction-level reference state
  int m_mem [16];
  int m_a, m_b, m_out, m_pc;
  bit m_z, m_c, m_n, m_halt;

  computer dut (
    .clk             (clk),
    .reset           (reset),
    .out_val         (out_val),
    .flag_zero_o     (flag_zero_o),
    .flag_carry_o    (flag_carry_o),
    .flag_negative_o (flag_negative_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, " A"},    32'(dut.u_register_A.latched_data), 32'(m_a));
    chk({tag, " OUT"},  32'(out_val), 32'(m_out));
    chk({tag, " PC"},   32'(dut.u_program_counter.counter_out), 32'(m_pc));
    chk({tag, " Z"},    32'(flag_zero_o), 32'(m_z));
    chk({tag, " C"},    32'(flag_carry_o), 32'(m_c));
    chk({tag, " N"},    32'(flag_negative_o), 32'(m_n));
    chk({tag, " HALT"}, 32'(dut.halt), 32'(m_halt));
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s M[%0d]", tag, i), 32'(dut.u_ram.mem[i]), 32'(m_mem[i]));
  endtask

  // ---------------- model ----------------
  task automatic model_reset();
    m_a = 0; m_b = 0; m_out = 0; m_pc = 0;
    m_z = 0; m_c = 0; m_n = 0; m_halt = 0;
  endtask

  task automatic model_exec();
    int op, arg, s;
    if (m_halt) return;
    op   = m_mem[m_pc] / 16;
    arg  = m_mem[m_pc] % 16;
    m_pc = (m_pc + 1) % 16;
    case (op)
      1: begin m_a = m_mem[arg]; m_z = (m_a == 0); m_n = (m_a >= 128); end
      2: begin
        m_b = m_mem[arg]; s = m_a + m_b;
        m_c = (s > 255); m_a = s % 256; m_z = (m_a == 0); m_n = (m_a >= 128);
      end
      3: begin
        m_b = m_mem[arg]; m_c = (m_a >= m_b);
        m_a = (m_a - m_b + 256) % 256; m_z = (m_a == 0); m_n = (m_a >= 128);
      end
      4:  m_mem[arg] = m_a;
      5:  begin m_a = arg; m_z = (m_a == 0); m_n = 0; end
      6:  m_pc = arg;
      7:  if (m_c) m_pc = arg;
      8:  if (m_z) m_pc = arg;
      9:  if (m_n) m_pc = arg;
      14: m_out = m_a;
      15: m_halt = 1;
      default: ;
    endcase
  endtask

  // ---------------- drivers ----------------
  task automatic load_ram();
    for (int i = 0; i < 16; i++) dut.u_ram.mem[i] = 8'(m_mem[i]);
  endtask

  // Holds reset for two edges, checks cleared state, releases after an edge.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    tick(2);
    model_reset();
    chk_state({tag, " reset"});
    chk({tag, " reset MAR"}, 32'(dut.u_register_MAR.latched_data), 32'd0);
    chk({tag, " reset IR"},  32'(dut.u_register_IR.latched_data), 32'd0);
    reset = 1'b0;
  endtask

  // Runs n instructions; the first after reset release takes 8 edges, the rest 7.
  task automatic run_insns(input string tag, input int n, input bit first);
    for (int i = 0; i < n; i++) begin
      tick((first && i == 0) ? 8 : 7);
      model_exec();
      chk_state($sformatf("%s i%0d", tag, i));
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;

    // Program 1: LDI/JZ taken/LDI/JZ untaken/OUTA/HLT
    clear_prog();
    m_mem[0] = 'h50; m_mem[1] = 'h85; m_mem[5] = 'h51;
    m_mem[6] = 'h89; m_mem[7] = 'hE0; m_mem[8] = 'hF0;
    load_ram();
    apply_reset("p1");
    run_insns("p1", 1, 1'b1);
    chk("p1 LDI0 A", 32'(dut.u_register_A.latched_data), 32'h00);
    chk("p1 LDI0 Z", 32'(flag_zero_o), 32'd1);
    chk("p1 LDI0 PC", 32'(dut.u_program_counter.counter_out), 32'd1);
    run_insns("p1", 1, 1'b0);
    chk("p1 JZ taken PC", 32'(dut.u_program_counter.counter_out), 32'd5);
    run_insns("p1", 2, 1'b0);
    chk("p1 JZ untaken PC", 32'(dut.u_program_counter.counter_out), 32'd7);
    run_insns("p1", 2, 1'b0);
    chk("p1 HLT halt", 32'(dut.halt), 32'd1);
    chk("p1 HLT PC", 32'(dut.u_program_counter.counter_out), 32'd9);
    chk("p1 HLT OUT", 32'(out_val), 32'h01);
    tick(30);
    chk_state("p1 halted stable");

    // Reset after halt reruns the same program with identical timing
    apply_reset("p1r");
    run_insns("p1r", 6, 1'b1);

    // Reset mid-instruction (during execute of LDI 1)
    apply_reset("p1m");
    run_insns("p1m", 2, 1'b1);
    tick(4);
    apply_reset("p1m abort");
    run_insns("p1m rerun", 6, 1'b1);

    // Program 2: ADD carry, SUB equal, SUB borrow, JC/JN
    clear_prog();
    m_mem[0] = 'h1E; m_mem[1] = 'h2D; m_mem[2] = 'h74; m_mem[3] = 'hF0;
    m_mem[4] = 'h55; m_mem[5] = 'h3C; m_mem[6] = 'h53; m_mem[7] = 'h3C;
    m_mem[8] = 'h9A; m_mem[9] = 'hF0; m_mem[10] = 'hE0; m_mem[11] = 'hF0;
    m_mem[12] = 'h05; m_mem[13] = 'h01; m_mem[14] = 'hFF;
    load_ram();
    apply_reset("p2");
    run_insns("p2", 2, 1'b1);
    chk("p2 ADD A", 32'(dut.u_register_A.latched_data), 32'h00);
    chk("p2 ADD Z", 32'(flag_zero_o), 32'd1);
    chk("p2 ADD C", 32'(flag_carry_o), 32'd1);
    run_insns("p2", 3, 1'b0);
    chk("p2 SUB eq A", 32'(dut.u_register_A.latched_data), 32'h00);
    chk("p2 SUB eq C", 32'(flag_carry_o), 32'd1);
    run_insns("p2", 2, 1'b0);
    chk("p2 SUB lt A", 32'(dut.u_register_A.latched_data), 32'hFE);
    chk("p2 SUB lt N", 32'(flag_negative_o), 32'd1);
    chk("p2 SUB lt C", 32'(flag_carry_o), 32'd0);
    run_insns("p2", 3, 1'b0);
    chk("p2 end OUT", 32'(out_val), 32'hFE);

    // Program 3: STA/LDA round trip
    clear_prog();
    m_mem[0] = 'h57; m_mem[1] = 'h4F; m_mem[2] = 'h50; m_mem[3] = 'h1F; m_mem[4] = 'hF0;
    load_ram();
    apply_reset("p3");
    run_insns("p3", 5, 1'b1);
    chk("p3 A", 32'(dut.u_register_A.latched_data), 32'h07);
    chk("p3 M15", 32'(dut.u_ram.mem[15]), 32'h07);
    chk_mem("p3");

    // Random programs against the model
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) m_mem[i] = int'($urandom_range(0, 255));
      load_ram();
      apply_reset($sformatf("rnd%0d", r));
      run_insns($sformatf("rnd%0d", r), 24, 1'b1);
      chk_mem($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
